// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider: a registered divided clock/enable, a period-start
// tick and a phase count, with divisor/high-time reloaded over a valid/ready config port.
module clk_div_prog #(
  parameter int WIDTH    = 8,
  parameter int DEF_DIV  = 2,
  parameter int DEF_HIGH = 0
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [WIDTH-1:0] cfg_high,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clkout,
  output logic             tick,
  output logic [WIDTH-1:0] phase,
  output logic             dbg_state
);

  // Handshake: a config word transfers on a clkin edge where cfg_valid and cfg_ready are
  // both 1; cfg_ready drops only while an accepted word waits for the next period boundary.

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Effective high time: 0 selects half the period, anything too long keeps one low cycle.
  function automatic logic [WIDTH-1:0] eff_high(input logic [WIDTH-1:0] d,
                                                input logic [WIDTH-1:0] h);
    logic [WIDTH-1:0] r;
    if (h == '0)
      r = d >> 1;
    else if (h >= d)
      r = d - ONE;
    else
      r = h;
    return r;
  endfunction

  localparam logic [WIDTH-1:0] DEF_DIV_W  = DEF_DIV[WIDTH-1:0];
  localparam logic [WIDTH-1:0] DEF_HIGH_W = eff_high(DEF_DIV_W, DEF_HIGH[WIDTH-1:0]);

  state_t           r_state,      w_state_n;
  logic [WIDTH-1:0] r_phase,      w_phase_n;
  logic             r_clkout,     w_clkout_n;
  logic             r_tick,       w_tick_n;
  logic             r_cfg_err,    w_cfg_err_n;
  logic [WIDTH-1:0] r_div_act,    w_div_act_n;
  logic [WIDTH-1:0] r_high_act,   w_high_act_n;
  logic             r_pend_valid, w_pend_valid_n;
  logic [WIDTH-1:0] r_pend_div,   w_pend_div_n;
  logic [WIDTH-1:0] r_pend_high,  w_pend_high_n;

  logic             w_accept;
  logic             w_div_ok;
  logic             w_cfg_ok;
  logic [WIDTH-1:0] w_cfg_high_eff;
  logic [WIDTH-1:0] w_phase_inc;
  logic             w_wrap;

  assign cfg_ready      = ~r_pend_valid;
  assign w_accept       = cfg_valid & cfg_ready;
  assign w_div_ok       = (cfg_div > ONE);
  assign w_cfg_ok       = w_accept & w_div_ok;
  assign w_cfg_high_eff = eff_high(cfg_div, cfg_high);
  assign w_phase_inc    = r_phase + ONE;
  assign w_wrap         = (r_phase == (r_div_act - ONE));

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_phase      <= '0;
      r_clkout     <= 1'b0;
      r_tick       <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_div_act    <= DEF_DIV_W;
      r_high_act   <= DEF_HIGH_W;
      r_pend_valid <= 1'b0;
      r_pend_div   <= '0;
      r_pend_high  <= '0;
    end else begin
      r_state      <= w_state_n;
      r_phase      <= w_phase_n;
      r_clkout     <= w_clkout_n;
      r_tick       <= w_tick_n;
      r_cfg_err    <= w_cfg_err_n;
      r_div_act    <= w_div_act_n;
      r_high_act   <= w_high_act_n;
      r_pend_valid <= w_pend_valid_n;
      r_pend_div   <= w_pend_div_n;
      r_pend_high  <= w_pend_high_n;
    end
  end

  always_comb begin
    w_state_n      = r_state;
    w_phase_n      = r_phase;
    w_clkout_n     = r_clkout;
    w_tick_n       = 1'b0;
    w_cfg_err_n    = w_accept & ~w_div_ok;
    w_div_act_n    = r_div_act;
    w_high_act_n   = r_high_act;
    w_pend_valid_n = r_pend_valid;
    w_pend_div_n   = r_pend_div;
    w_pend_high_n  = r_pend_high;

    unique case (r_state)
      ST_IDLE: begin
        w_phase_n  = '0;
        w_clkout_n = 1'b0;
        if (w_cfg_ok) begin
          w_div_act_n  = cfg_div;
          w_high_act_n = w_cfg_high_eff;
        end
        if (en) begin
          w_state_n  = ST_RUN;
          w_clkout_n = 1'b1;
          w_tick_n   = 1'b1;
        end
      end

      ST_RUN: begin
        if (!en || w_wrap) begin
          // Period boundary (natural or truncated): the only place new timing takes effect.
          w_phase_n = '0;
          if (r_pend_valid) begin
            w_div_act_n    = r_pend_div;
            w_high_act_n   = r_pend_high;
            w_pend_valid_n = 1'b0;
          end else if (w_cfg_ok) begin
            w_div_act_n  = cfg_div;
            w_high_act_n = w_cfg_high_eff;
          end
          if (!en) begin
            w_state_n  = ST_IDLE;
            w_clkout_n = 1'b0;
          end else begin
            w_clkout_n = 1'b1;
            w_tick_n   = 1'b1;
          end
        end else begin
          w_phase_n  = w_phase_inc;
          w_clkout_n = (w_phase_inc < r_high_act);
          if (w_cfg_ok) begin
            w_pend_valid_n = 1'b1;
            w_pend_div_n   = cfg_div;
            w_pend_high_n  = w_cfg_high_eff;
          end
        end
      end

      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
  end

  assign clkout    = r_clkout;
  assign tick      = r_tick;
  assign phase     = r_phase;
  assign cfg_err   = r_cfg_err;
  assign dbg_state = (r_state == ST_RUN);

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: default ratio, reconfiguration in IDLE/RUN, rejected
// configs, high-time clamp, enable drop and reset with a pending config.
module tb_clk_div_prog;

  localparam int WIDTH = 8;

  logic             clkin = 1'b0;
  logic             rst_n;
  logic             en;
  logic             cfg_valid;
  logic [WIDTH-1:0] cfg_div;
  logic [WIDTH-1:0] cfg_high;
  logic             cfg_ready;
  logic             cfg_err;
  logic             clkout;
  logic             tick;
  logic [WIDTH-1:0] phase;
  logic             dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  clk_div_prog #(.WIDTH(WIDTH), .DEF_DIV(2), .DEF_HIGH(0)) dut (
    .clkin     (clkin),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .clkout    (clkout),
    .tick      (tick),
    .phase     (phase),
    .dbg_state (dbg_state)
  );

  always #5 clkin = ~clkin;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // One clkin edge; outputs are then sampled 1ns later, well clear of the edge.
  task automatic step();
    @(posedge clkin);
    #1;
  endtask

  task automatic set_cfg(input logic v, input int d, input int h);
    cfg_valid = v;
    cfg_div   = d[WIDTH-1:0];
    cfg_high  = h[WIDTH-1:0];
  endtask

  // Step n cycles; cycle index k counts from the start of an aligned period.
  task automatic run_check(input string tag, input int div, input int high,
                           input int start, input int n);
    for (int k = start; k < start + n; k++) begin
      step();
      check($sformatf("%s clkout k=%0d", tag, k), 32'(clkout), 32'((k % div) < high));
      check($sformatf("%s tick k=%0d", tag, k),   32'(tick),   32'((k % div) == 0));
      check($sformatf("%s phase k=%0d", tag, k),  32'(phase),  32'(k % div));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    set_cfg(1'b0, 0, 0);

    repeat (2) step();
    check("rst clkout", 32'(clkout), 0);
    check("rst tick", 32'(tick), 0);
    check("rst phase", 32'(phase), 0);
    check("rst ready", 32'(cfg_ready), 1);
    check("rst err", 32'(cfg_err), 0);
    rst_n = 1'b1;
    step();
    check("idle clkout", 32'(clkout), 0);

    // Default divide-by-2, high 1: 10 repeating
    en = 1'b1;
    run_check("def", 2, 1, 0, 6);

    // IDLE reconfig div=5 high=auto -> high 2: 11000
    en = 1'b0;
    step();
    check("drop clkout", 32'(clkout), 0);
    check("drop phase", 32'(phase), 0);
    set_cfg(1'b1, 5, 0);
    step();
    set_cfg(1'b0, 0, 0);
    check("idle cfg ready", 32'(cfg_ready), 1);
    check("idle cfg err", 32'(cfg_err), 0);
    en = 1'b1;
    run_check("d5", 5, 2, 0, 10);

    // RUN at div=4 high=1, then div=6 high=4 requested at phase 1
    en = 1'b0;
    step();
    set_cfg(1'b1, 4, 1);
    step();
    set_cfg(1'b0, 0, 0);
    en = 1'b1;
    run_check("d4", 4, 1, 0, 2);
    set_cfg(1'b1, 6, 4);
    step();
    set_cfg(1'b0, 0, 0);
    check("pend ready p2", 32'(cfg_ready), 0);
    check("pend phase p2", 32'(phase), 2);
    check("pend clkout p2", 32'(clkout), 0);
    step();
    check("pend ready p3", 32'(cfg_ready), 0);
    check("pend phase p3", 32'(phase), 3);
    check("pend clkout p3", 32'(clkout), 0);
    step();
    check("apply tick", 32'(tick), 1);
    check("apply clkout", 32'(clkout), 1);
    check("apply phase", 32'(phase), 0);
    check("apply ready", 32'(cfg_ready), 1);
    run_check("d6h4", 6, 4, 1, 11);

    // Rejected configs div=1 then div=0, waveform stays 111100
    set_cfg(1'b1, 1, 3);
    step();
    check("err1 pulse", 32'(cfg_err), 1);
    check("err1 ready", 32'(cfg_ready), 1);
    check("err1 phase", 32'(phase), 0);
    check("err1 tick", 32'(tick), 1);
    set_cfg(1'b1, 0, 0);
    step();
    set_cfg(1'b0, 0, 0);
    check("err0 pulse", 32'(cfg_err), 1);
    check("err0 ready", 32'(cfg_ready), 1);
    check("err0 phase", 32'(phase), 1);
    step();
    check("err clear", 32'(cfg_err), 0);
    check("err clr phase", 32'(phase), 2);
    check("err clr clkout", 32'(clkout), 1);
    run_check("d6h4 post", 6, 4, 15, 9);

    // div=4 high=9 accepted on a wrap edge, clamped to 3: 1110
    set_cfg(1'b1, 4, 9);
    step();
    set_cfg(1'b0, 0, 0);
    check("clamp tick", 32'(tick), 1);
    check("clamp phase", 32'(phase), 0);
    check("clamp ready", 32'(cfg_ready), 1);
    run_check("clamp", 4, 3, 1, 7);

    // en drop at phase 2 of div=6 (auto high 3), then restart
    en = 1'b0;
    step();
    set_cfg(1'b1, 6, 0);
    step();
    set_cfg(1'b0, 0, 0);
    en = 1'b1;
    run_check("d6h3", 6, 3, 0, 3);
    en = 1'b0;
    step();
    check("trunc clkout", 32'(clkout), 0);
    check("trunc phase", 32'(phase), 0);
    check("trunc tick", 32'(tick), 0);
    check("trunc state", 32'(dbg_state), 0);
    step();
    check("trunc idle clkout", 32'(clkout), 0);
    en = 1'b1;
    run_check("restart", 6, 3, 0, 7);

    // Pending config then reset mid-period; config offered during reset is lost
    run_check("pre rst", 6, 3, 7, 1);
    set_cfg(1'b1, 8, 2);
    step();
    set_cfg(1'b0, 0, 0);
    check("pre rst ready", 32'(cfg_ready), 0);
    rst_n = 1'b0;
    set_cfg(1'b1, 5, 0);
    step();
    check("mid rst clkout", 32'(clkout), 0);
    check("mid rst phase", 32'(phase), 0);
    check("mid rst tick", 32'(tick), 0);
    check("mid rst ready", 32'(cfg_ready), 1);
    step();
    check("rst+cfg err", 32'(cfg_err), 0);
    check("rst+cfg ready", 32'(cfg_ready), 1);
    rst_n = 1'b1;
    set_cfg(1'b0, 0, 0);
    run_check("post rst", 2, 1, 0, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
